// File: rtl/fsm_step_ctrl.sv
// fsm_step_ctrl: steps a 2-bit state register through an 8-entry input sequence, manually or on a prescaler tick.
module fsm_step_ctrl #(
  parameter int DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic        mode,
  input  logic [15:0] seq,
  input  logic        ny2,
  input  logic        ny1,
  input  logic        z,
  output logic        x2,
  output logic        x1,
  output logic        y2,
  output logic        y1,
  output logic [2:0]  idx,
  output logic [7:0]  z_hist,
  output logic        busy,
  output logic        done
);
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0]    start_q, start_d, step_q, step_d;
  logic [1:0]    mode_q, mode_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d, nidx;
  logic [1:0]    x_q, x_d, y_q, y_d;
  logic [7:0]    zh_q, zh_d;
  logic          start_edge, step_edge, mode_s, tick, commit;
  assign start_edge = start_q[1] & ~start_q[2];
  assign step_edge  = step_q[1] & ~step_q[2];
  assign mode_s     = mode_q[1];
  assign tick       = (state_q == RUN) && mode_s && (cnt_q == LAST);
  assign commit     = (state_q == RUN) && (mode_s ? tick : step_edge);
  assign nidx       = idx_q + 3'd1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      start_q  <= '0;
      step_q   <= '0;
      mode_q   <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      zh_q     <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      step_q   <= step_d;
      mode_q   <= mode_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      y_q      <= y_d;
      zh_q     <= zh_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (start_edge) state_d = RUN;
    else if (commit && idx_q == 3'd7) state_d = DONE;
  end
  // start wins over a same-cycle commit, so the load branch comes first
  always_comb begin
    start_d  = {start_q[1:0], start};
    step_d   = {step_q[1:0], step};
    mode_d   = {mode_q[0], mode};
    shadow_d = shadow_q;
    idx_d    = idx_q;
    x_d      = x_q;
    y_d      = y_q;
    zh_d     = zh_q;
    cnt_d    = (state_q == RUN && mode_s && !tick) ? cnt_q + 1'b1 : '0;
    if (start_edge) begin
      shadow_d = seq;
      idx_d    = '0;
      x_d      = seq[1:0];
      y_d      = '0;
      zh_d     = '0;
      cnt_d    = '0;
    end else if (commit) begin
      y_d   = {ny2, ny1};
      zh_d  = {zh_q[6:0], z};
      idx_d = (idx_q == 3'd7) ? idx_q : nidx;
      x_d   = (idx_q == 3'd7) ? x_q : shadow_q[{nidx, 1'b0} +: 2];
    end
  end
  always_comb begin
    {x2, x1} = x_q;
    {y2, y1} = y_q;
    idx      = idx_q;
    z_hist   = zh_q;
    busy     = (state_q == RUN);
    done     = (state_q == DONE);
  end
endmodule

// File: tb/tb_fsm_step_ctrl.sv
// tb_fsm_step_ctrl: randomized sequences against a per-step reference of the sequencer with a toy circuit under study.
module tb_fsm_step_ctrl;
  logic        clk = 0, rst = 1, start = 0, step = 0, mode = 0;
  logic [15:0] seq = '0;
  logic        x2, x1, y2, y1, busy, done, ny2, ny1, z;
  logic [2:0]  idx;
  logic [7:0]  z_hist;
  int          n_chk = 0, n_err = 0;

  fsm_step_ctrl #(.DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .mode(mode), .seq(seq),
    .ny2(ny2), .ny1(ny1), .z(z), .x2(x2), .x1(x1), .y2(y2), .y1(y1),
    .idx(idx), .z_hist(z_hist), .busy(busy), .done(done)
  );

  // circuit under study: next state copies the inputs, output is y2 & y1
  assign ny2 = x2;
  assign ny1 = x1;
  assign z   = y2 & y1;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] entry(input logic [15:0] s, input int k);
    return 2'((s >> (2 * k)) & 16'h3);
  endfunction

  // y before commit k is the entry applied at commit k-1, starting from 00
  function automatic logic [1:0] y_before(input logic [15:0] s, input int k);
    return (k == 0) ? 2'b00 : entry(s, k - 1);
  endfunction

  function automatic logic [7:0] zh_after(input logic [15:0] s, input int n);
    logic [7:0] h = 0;
    for (int k = 0; k < n; k++) h = (h << 1) | 8'(&y_before(s, k));
    return h;
  endfunction

  // returns at the negedge right after the load edge
  task automatic press_start();
    start = 1;
    repeat (3) @(negedge clk);
    start = 0;
  endtask

  task automatic press_step(input int hold);
    step = 1;
    repeat (hold) @(negedge clk);
    step = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_step(input logic [15:0] s, input int k);
    check("idx", 16'(idx), 16'(k));
    check("x", 16'({x2, x1}), 16'(entry(s, k)));
    check("y", 16'({y2, y1}), 16'(y_before(s, k)));
    check("zh", 16'(z_hist), 16'(zh_after(s, k)));
  endtask

  task automatic run_seq(input logic [15:0] s, input logic auto_m);
    mode = auto_m;
    seq = s;
    repeat (4) @(negedge clk);
    press_start();
    seq = ~s;
    check("busy_rise", 16'({busy, done}), 16'b10);
    for (int k = 0; k < 8; k++) begin
      check_step(s, k);
      if (auto_m) begin
        repeat (3) @(negedge clk);
        check("auto_early", 16'(idx), 16'(k));
        if (k == 7) check("done_early", 16'(done), 16'd0);
        @(negedge clk);
      end else press_step(int'($urandom_range(1, 5)));
    end
    check("done", 16'({busy, done}), 16'b01);
    check("final_idx", 16'(idx), 16'd7);
    check("final_x", 16'({x2, x1}), 16'(entry(s, 7)));
    check("final_y", 16'({y2, y1}), 16'(entry(s, 7)));
    check("final_zh", 16'(z_hist), 16'(zh_after(s, 8)));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("reset", {x2, x1, y2, y1, idx, z_hist, busy, done}, 16'h0);

    run_seq(16'hB478, 1'b0);
    check("fixed_manual_zh", 16'(z_hist), 16'h11);
    mode = 0;
    press_step(2);
    check("step_in_done", 16'({idx, z_hist}), 16'({3'd7, 8'h11}));

    run_seq(16'hB478, 1'b1);
    check("fixed_auto_zh", 16'(z_hist), 16'h11);

    mode = 0;
    seq = 16'hB478;
    repeat (4) @(negedge clk);
    press_start();
    press_step(50);
    check("held_step", 16'(idx), 16'd1);

    mode = 1;
    repeat (4) @(negedge clk);
    press_start();
    repeat (13) @(negedge clk);
    check("pre_coincide", 16'(idx), 16'd3);
    start = 1;
    repeat (2) @(negedge clk);
    check("before_tick", 16'(idx), 16'd3);
    start = 0;
    @(negedge clk);
    check("coincide", {x2, x1, y2, y1, idx, z_hist, busy, done}, 16'h0002);
    repeat (3) @(negedge clk);
    check("restart_wait", 16'(idx), 16'd0);
    @(negedge clk);
    check("restart_tick", 16'(idx), 16'd1);

    mode = 0;
    repeat (4) @(negedge clk);
    press_start();
    for (int k = 0; k < 5; k++) press_step(2);
    check("five_commits", 16'(idx), 16'd5);
    #2 rst = 1;
    #1 check("async_reset", {x2, x1, y2, y1, idx, z_hist, busy, done}, 16'h0);
    @(negedge clk);
    rst = 0;
    run_seq(16'hB478, 1'b0);
    check("post_reset_zh", 16'(z_hist), 16'h11);

    for (int r = 0; r < 4; r++) run_seq(16'($urandom), 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fsm_step_ctrl.md
# fsm_step_ctrl

Sequencing controller for the two-input, two-state-bit synchronous sequential circuits built in the lab exercises. These are next-state/output logic blocks with inputs x2,x1, present state y2,y1, next state ny2,ny1 and output z. The block owns the y2,y1 state register and replays an 8-entry x2,x1 input sequence taken from switches. It advances one step per button press (manual) or per prescaler tick (auto) and records z into an 8-bit history shown on LEDs. It sits on the EGO1 top level, between the board I/O and the combinational circuit under study.

## Interface
- DIV, default 100_000_000: auto-step period in clk cycles, ≥1.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  button, level; rising edge (after sync) loads sequence and begins run.
- step  in  1  button, level; rising edge commits one step in manual mode.
- mode  in  1  0 = manual, 1 = auto; synchronized, used live.
- seq  in  16  input sequence; entry k = seq[2k+1:2k] = {x2,x1}, k = 0..7.
- ny2, ny1  in  1 each  next state from the circuit under study.
- z  in  1  output from the circuit under study, a function of current x,y.
- x2, x1  out  1 each  registered input pair driven to the circuit.
- y2, y1  out  1 each  state register driven to the circuit.
- idx  out  3  index of the entry currently applied.
- z_hist  out  8  z history; newest sample in bit 0.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

## Operation
- start, step and mode each pass through a 2-FF synchronizer. start and step then go through a third register for edge detection: edge = s2 & ~s3.
- States: IDLE, RUN, DONE.
- IDLE:
  - x = 00; y holds; busy = done = 0.
  - On start edge: shadow ← seq, idx ← 0, x ← seq[1:0], y ← 00, z_hist ← 0, prescaler ← 0, go to RUN.
- RUN: a commit event is a step edge when mode = 0, or a prescaler tick when mode = 1. Each commit does:
  - y2,y1 ← ny2,ny1.
  - z_hist ← {z_hist[6:0], z}, with z sampled in the same cycle, before y changes.
  - If idx = 7: go to DONE; idx and x hold.
  - Otherwise: idx ← idx+1 and x ← shadow entry idx+1.
- Prescaler:
  - Counts only in RUN.
  - Tick when count = DIV−1, then wraps to 0.
  - Cleared on entering RUN and whenever mode = 0.
  - With DIV = 1, a tick occurs every cycle.
- DONE: y, x, idx and z_hist hold; done = 1. A start edge restarts exactly as from IDLE.
- A start edge in RUN restarts the sequence (reload, y ← 00).
- A start edge and a commit in the same cycle: start wins and the commit is discarded.
- Step edges in IDLE or DONE are ignored.
- Changes on seq after load have no effect until the next start.

## Timing
- Reset values: state IDLE, x2 = x1 = 0, y2 = y1 = 0, idx = 0, z_hist = 0x00, busy = 0, done = 0. Synchronizers, prescaler and shadow are all 0.
- Async reset mid-run aborts immediately to the reset values.
- Button latency: input high before clk edge E gives a commit (or restart) at edge E+2. Outputs update after E+2.
- One commit per button press, regardless of hold length.
- Auto mode: first commit DIV cycles after entering RUN, then every DIV cycles. DONE is reached 8·DIV cycles after entry.
- busy rises and done falls on the same edge as the load.
- done rises on the 8th commit edge.

## Test plan
The bench models the circuit as ny2 = x2, ny1 = x1, z = y2 & y1, with seq = 16'hB478 (entries 00,10,11,01,00,01,11,10).
- Reset: assert rst mid-cycle → all outputs 0 asynchronously; state IDLE.
- Manual: pulse start, then 8 step presses → y before commits follows 00,00,10,11,01,00,01,11. Final y = 10, z_hist = 8'h11, done = 1, idx = 7.
- Auto: mode = 1, DIV = 4, pulse start → commits every 4 cycles; done asserts exactly 32 cycles after busy rises; same final values as the manual case.
- Button held for 50 cycles in manual → exactly one commit (idx +1).
- Start edge coincident with an auto tick after 3 commits → idx = 0, y = 00, z_hist = 0, x = 00; that tick is discarded.
- Async reset after the 5th commit → immediate IDLE with reset values. A following start runs a full clean sequence, ending with z_hist = 8'h11.
